// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter between the core
// load/store path and the DMA/program-loader port.
package dmem_arb_pkg;

  localparam int unsigned DEF_AW        = 32;
  localparam int unsigned DEF_DW        = 32;
  localparam int unsigned DEF_MAX_BURST = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CORE = 2'b01,
    OWN_DMA  = 2'b10
  } owner_t;

  // Round-robin partner of a requester; NONE maps to CORE so a cleared
  // history still resolves a tie.
  function automatic owner_t other_side(input owner_t side);
    return (side == OWN_CORE) ? OWN_DMA : OWN_CORE;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the core, DMA and data-memory signals around the arbiter.
// master = requesters plus memory (testbench/system side), slave = arbiter.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);

  // core load/store path
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic [DW-1:0] c_rdata;
  logic          c_stall;

  // DMA / program loader
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_gnt;

  // data memory
  logic          dm_read;
  logic          dm_write;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_rdata, c_stall,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_gnt,
    input  dm_read, dm_write, dm_addr, dm_wdata,
    output dm_rdata
  );

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_rdata, c_stall,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_gnt,
    output dm_read, dm_write, dm_addr, dm_wdata,
    input  dm_rdata
  );

endinterface

// File: rtl/dmem_rr_pick.sv
// Two-way grant chooser: burst owner keeps the grant until MAX_BURST is
// reached with the other side waiting, ties go to the side not served last.
module dmem_rr_pick
  import dmem_arb_pkg::*;
#(
  parameter  int unsigned MAX_BURST = DEF_MAX_BURST,
  localparam int unsigned CW        = $clog2(MAX_BURST + 1)
) (
  input  owner_t        owner,
  input  logic [CW-1:0] cnt,
  input  logic          c_req,
  input  logic          d_req,
  input  owner_t        last,
  output owner_t        grantee
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

  logic burst_open;

  assign burst_open = (cnt < CNT_MAX);

  always_comb begin
    grantee = OWN_NONE;
    if (owner == OWN_CORE && c_req && (burst_open || !d_req)) begin
      grantee = OWN_CORE;
    end else if (owner == OWN_DMA && d_req && (burst_open || !c_req)) begin
      grantee = OWN_DMA;
    end else if (c_req && d_req) begin
      grantee = other_side(last);
    end else if (c_req) begin
      grantee = OWN_CORE;
    end else if (d_req) begin
      grantee = OWN_DMA;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the core and the DMA port.
// Grant is combinational; a granted access completes in its grant cycle.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW        = DEF_AW,
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned   CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  owner_t        owner, owner_n;
  owner_t        last, last_n;
  owner_t        pick, gnt;
  logic [CW-1:0] cnt, cnt_n;
  logic          gnt_core, gnt_dma, we_sel;

  dmem_rr_pick #(
    .MAX_BURST (MAX_BURST)
  ) u_pick (
    .owner   (owner),
    .cnt     (cnt),
    .c_req   (bus.c_req),
    .d_req   (bus.d_req),
    .last    (last),
    .grantee (pick)
  );

  // While reset is held the memory must see no access at all.
  always_comb begin
    gnt = OWN_NONE;
    if (reset) begin
      gnt = pick;
    end
  end

  assign gnt_core = (gnt == OWN_CORE);
  assign gnt_dma  = (gnt == OWN_DMA);

  always_ff @(posedge clk) begin
    if (!reset) begin
      owner <= OWN_NONE;
      cnt   <= '0;
      last  <= OWN_DMA;
    end else begin
      owner <= owner_n;
      cnt   <= cnt_n;
      last  <= last_n;
    end
  end

  always_comb begin
    owner_n = gnt;
    last_n  = last;
    cnt_n   = '0;
    if (gnt != OWN_NONE) begin
      last_n = gnt;
      if (gnt != owner) begin
        cnt_n = CNT_ONE;
      end else if (cnt == CNT_MAX) begin
        cnt_n = cnt;
      end else begin
        cnt_n = cnt + CNT_ONE;
      end
    end
  end

  always_comb begin
    we_sel       = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
    bus.c_rdata  = '0;
    bus.d_rdata  = '0;
    if (gnt_core) begin
      we_sel       = bus.c_we;
      bus.dm_addr  = bus.c_addr;
      bus.dm_wdata = bus.c_wdata;
      bus.c_rdata  = bus.dm_rdata;
    end else if (gnt_dma) begin
      we_sel       = bus.d_we;
      bus.dm_addr  = bus.d_addr;
      bus.dm_wdata = bus.d_wdata;
      bus.d_rdata  = bus.dm_rdata;
    end
  end

  assign bus.dm_read  = (gnt_core | gnt_dma) & ~we_sel;
  assign bus.dm_write = (gnt_core | gnt_dma) & we_sel;
  assign bus.c_stall  = bus.c_req & ~gnt_core;
  assign bus.d_gnt    = gnt_dma;

  a_no_rw_overlap : assert property (@(posedge clk) !(bus.dm_read && bus.dm_write));
  a_single_grant  : assert property (@(posedge clk) !(gnt_core && gnt_dma));

endmodule
